// File: rtl/conf_stream_sequencer.sv
// Configuration-session sequencer: streams conf words onto the shared conf bus, lets the
// bus pipeline drain for SETTLE_CYCLES, then enables the PC/network for a programmed run.
module conf_stream_sequencer #(
    parameter int CONF_WIDTH    = 64,
    parameter int CNT_WIDTH     = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  stall,
    input  logic [CNT_WIDTH-1:0]  num_conf,
    input  logic [CNT_WIDTH-1:0]  run_len,
    input  logic [CONF_WIDTH-1:0] conf_in,
    input  logic                  conf_in_valid,
    output logic                  conf_in_ready,
    output logic [CONF_WIDTH-1:0] conf_bus_out,
    output logic                  en_pc_net,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  conf_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t                state_q, state_d;
    logic [CONF_WIDTH-1:0] conf_bus_q, conf_bus_d;
    logic [CNT_WIDTH-1:0]  conf_count_q, conf_count_d;
    logic [CNT_WIDTH-1:0]  num_conf_q, num_conf_d;
    logic [CNT_WIDTH-1:0]  run_len_q, run_len_d;
    logic [CNT_WIDTH-1:0]  run_cnt_q, run_cnt_d;
    logic [7:0]            settle_cnt_q, settle_cnt_d;
    logic [CNT_WIDTH-1:0]  conf_count_inc;
    logic [CNT_WIDTH-1:0]  run_cnt_inc;
    logic                  xfer;

    // An unbounded run must not wrap back to zero, so the run counter sticks at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign conf_in_ready  = (state_q == S_LOAD);
    assign en_pc_net      = (state_q == S_RUN) && !stall;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign conf_bus_out   = conf_bus_q;
    assign conf_count     = conf_count_q;
    assign xfer           = conf_in_valid && conf_in_ready;
    assign conf_count_inc = conf_count_q + CNT_WIDTH'(1);
    assign run_cnt_inc    = sat_inc(run_cnt_q);

    always_comb begin
        state_d      = state_q;
        conf_bus_d   = '0;
        conf_count_d = conf_count_q;
        num_conf_d   = num_conf_q;
        run_len_d    = run_len_q;
        run_cnt_d    = run_cnt_q;
        settle_cnt_d = settle_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_conf_d   = num_conf;
                    run_len_d    = run_len;
                    conf_count_d = '0;
                    run_cnt_d    = '0;
                    settle_cnt_d = '0;
                    state_d      = (num_conf != '0) ? S_LOAD : S_SETTLE;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    conf_bus_d   = conf_in;
                    conf_count_d = conf_count_inc;
                    if (conf_count_inc == num_conf_q) begin
                        state_d = S_SETTLE;
                    end
                end
                if (stop) begin
                    state_d = S_DONE;
                end
            end
            S_SETTLE: begin
                settle_cnt_d = settle_cnt_q + 8'd1;
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_RUN;
                end
                if (stop) begin
                    state_d = S_DONE;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    run_cnt_d = run_cnt_inc;
                    if ((run_len_q != '0) && (run_cnt_inc == run_len_q)) begin
                        state_d = S_DONE;
                    end
                end
                if (stop) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            conf_bus_q   <= '0;
            conf_count_q <= '0;
            num_conf_q   <= '0;
            run_len_q    <= '0;
            run_cnt_q    <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            conf_bus_q   <= conf_bus_d;
            conf_count_q <= conf_count_d;
            num_conf_q   <= num_conf_d;
            run_len_q    <= run_len_d;
            run_cnt_q    <= run_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

endmodule

// File: tb/tb_conf_stream_sequencer.sv
// Self-checking bench for conf_stream_sequencer: directed and random sessions compared
// against a session-timeline reference model built from the stimulus before each run.
module tb_conf_stream_sequencer;

    localparam int CW   = 64;
    localparam int NW   = 16;
    localparam int S    = 4;
    localparam int MAXC = 128;
    localparam int NEVER = 100000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          stall;
    logic [NW-1:0] num_conf;
    logic [NW-1:0] run_len;
    logic [CW-1:0] conf_in;
    logic          conf_in_valid;
    logic          conf_in_ready;
    logic [CW-1:0] conf_bus_out;
    logic          en_pc_net;
    logic          busy;
    logic          done;
    logic [NW-1:0] conf_count;

    int n_checks = 0;
    int n_errors = 0;

    // Session stimulus, indexed by cycle relative to the start cycle (cycle 0).
    logic [CW-1:0] w_conf  [MAXC];
    bit            w_valid [MAXC];
    bit            w_stall [MAXC];
    bit            w_start [MAXC];
    int            stop_at;
    int            s_num;
    int            s_run;

    // Expected per-cycle outputs.
    logic [CW-1:0] e_bus   [MAXC];
    bit            e_ready [MAXC];
    bit            e_en    [MAXC];
    bit            e_busy  [MAXC];
    bit            e_done  [MAXC];
    bit            e_x     [MAXC];
    int            e_cnt   [MAXC];
    int            end_cyc;

    conf_stream_sequencer #(
        .CONF_WIDTH   (CW),
        .CNT_WIDTH    (NW),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .stall        (stall),
        .num_conf     (num_conf),
        .run_len      (run_len),
        .conf_in      (conf_in),
        .conf_in_valid(conf_in_valid),
        .conf_in_ready(conf_in_ready),
        .conf_bus_out (conf_bus_out),
        .en_pc_net    (en_pc_net),
        .busy         (busy),
        .done         (done),
        .conf_count   (conf_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            w_conf[i]  = '0;
            w_valid[i] = 1'b0;
            w_stall[i] = 1'b0;
            w_start[i] = 1'b0;
        end
        stop_at = NEVER;
    endtask

    // Session timeline: load ends at the Nth accepted word, settle lasts S cycles,
    // run lasts until run_len enabled cycles; a stop cuts the session at its cycle.
    task automatic build_expect();
        int  c;
        int  xfers;
        int  last;
        int  run_cnt;
        int  cnt;
        bit  ended;
        for (int i = 0; i < MAXC; i++) begin
            e_bus[i] = '0; e_ready[i] = 0; e_en[i] = 0;
            e_busy[i] = 0; e_done[i] = 0; e_x[i] = 0; e_cnt[i] = 0;
        end
        xfers = 0; ended = 0; last = 0; c = 0;
        if (s_num > 0) begin
            c = 1;
            while (1) begin
                e_ready[c] = 1;
                if (w_valid[c]) begin
                    xfers++;
                    e_x[c] = 1;
                    e_bus[c+1] = w_conf[c];
                end
                if (c == stop_at) begin
                    ended = 1;
                    break;
                end
                if (xfers == s_num) break;
                c++;
            end
            last = c;
        end
        if (!ended) begin
            for (int k = 1; k <= S; k++) begin
                c = last + k;
                if (c == stop_at) begin
                    ended = 1;
                    break;
                end
            end
        end
        if (!ended) begin
            c = last + S;
            run_cnt = 0;
            while (1) begin
                c++;
                e_en[c] = !w_stall[c];
                run_cnt += int'(e_en[c]);
                if (c == stop_at) break;
                if (s_run != 0 && run_cnt == s_run) break;
            end
        end
        end_cyc = c;
        for (int i = 1; i <= end_cyc + 1; i++) e_busy[i] = 1;
        e_done[end_cyc+1] = 1;
        cnt = 0;
        for (int i = 1; i < MAXC; i++) begin
            e_cnt[i] = cnt;
            cnt += int'(e_x[i]);
        end
    endtask

    task automatic run_session(input string name);
        build_expect();
        for (int c = 0; c <= end_cyc + 3; c++) begin
            @(negedge clk);
            start         = (c == 0) || (c <= end_cyc + 1 && w_start[c]);
            num_conf      = (c == 0) ? NW'(s_num) : NW'($urandom_range(0, 7));
            run_len       = (c == 0) ? NW'(s_run) : NW'($urandom_range(0, 7));
            conf_in       = w_conf[c];
            conf_in_valid = w_valid[c];
            stall         = w_stall[c];
            stop          = (c == stop_at) || (c == end_cyc + 2);
            #1;
            if (c == 0) begin
                chk($sformatf("%s c0 busy", name), 64'(busy), 64'(0));
            end else begin
                chk($sformatf("%s c%0d bus", name, c), conf_bus_out, e_bus[c]);
                chk($sformatf("%s c%0d ready", name, c), 64'(conf_in_ready), 64'(e_ready[c]));
                chk($sformatf("%s c%0d en", name, c), 64'(en_pc_net), 64'(e_en[c]));
                chk($sformatf("%s c%0d busy", name, c), 64'(busy), 64'(e_busy[c]));
                chk($sformatf("%s c%0d done", name, c), 64'(done), 64'(e_done[c]));
                chk($sformatf("%s c%0d count", name, c), 64'(conf_count), 64'(e_cnt[c]));
            end
        end
        @(negedge clk);
        start = 0; stop = 0; conf_in_valid = 0; stall = 0;
    endtask

    task automatic random_stim();
        clear_stim();
        s_num = int'($urandom_range(0, 4));
        s_run = int'($urandom_range(0, 6));
        if (s_run == 0 || $urandom_range(0, 2) == 0) stop_at = int'($urandom_range(1, 40));
        for (int c = 0; c < MAXC; c++) begin
            w_conf[c]  = {$urandom, $urandom};
            w_valid[c] = (c >= 40) ? 1'b1 : ($urandom_range(0, 9) < 7);
            w_stall[c] = (c >= 60) ? 1'b0 : ($urandom_range(0, 9) < 3);
            w_start[c] = ($urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; stall = 0;
        num_conf = '0; run_len = '0; conf_in = '0; conf_in_valid = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset bus", conf_bus_out, 64'(0));
        chk("reset ready", 64'(conf_in_ready), 64'(0));
        chk("reset en", 64'(en_pc_net), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset count", 64'(conf_count), 64'(0));
        @(negedge clk);
        rst = 0;

        // Three back-to-back words
        clear_stim();
        s_num = 3; s_run = 5;
        w_conf[1] = 64'h11; w_conf[2] = 64'h22; w_conf[3] = 64'h33;
        for (int c = 1; c <= 3; c++) w_valid[c] = 1;
        run_session("b2b");

        // Toggling valid
        clear_stim();
        s_num = 3; s_run = 5;
        w_conf[1] = 64'h11; w_conf[3] = 64'h22; w_conf[5] = 64'h33;
        w_conf[2] = 64'hdead; w_conf[4] = 64'hbeef;
        w_valid[1] = 1; w_valid[3] = 1; w_valid[5] = 1;
        run_session("gap");

        // No conf words
        clear_stim();
        s_num = 0; s_run = 2;
        run_session("noconf");

        // Stall on the second run cycle (run begins at cycle S+1)
        clear_stim();
        s_num = 0; s_run = 4;
        w_stall[S+2] = 1;
        run_session("stall");

        // Unbounded run ended by stop on the 10th run cycle
        clear_stim();
        s_num = 0; s_run = 0;
        stop_at = S + 10;
        run_session("unbounded");

        // Stop in load after one of three words
        clear_stim();
        s_num = 3; s_run = 5;
        w_conf[1] = 64'haa; w_valid[1] = 1;
        stop_at = 2;
        run_session("loadstop");

        // Reset mid-load with start asserted while busy
        @(negedge clk);
        start = 1; num_conf = 16'd3; run_len = 16'd5;
        @(negedge clk);
        start = 0; conf_in = 64'h0123; conf_in_valid = 1;
        @(negedge clk);
        conf_in = 64'h4567;
        @(negedge clk);
        #1;
        chk("midload busy", 64'(busy), 64'(1));
        chk("midload count", 64'(conf_count), 64'(2));
        chk("midload bus", conf_bus_out, 64'h4567);
        rst = 1; start = 1; stop = 1; conf_in = 64'h89ab;
        @(negedge clk);
        #1;
        chk("rst bus", conf_bus_out, 64'(0));
        chk("rst ready", 64'(conf_in_ready), 64'(0));
        chk("rst en", 64'(en_pc_net), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst count", 64'(conf_count), 64'(0));
        rst = 0; start = 0; stop = 0; conf_in_valid = 0;

        // Normal session after reset with starts landing during run
        clear_stim();
        s_num = 2; s_run = 3;
        w_conf[1] = 64'hc0de; w_conf[2] = 64'hf00d;
        w_valid[1] = 1; w_valid[2] = 1;
        for (int c = 1; c < 20; c++) w_start[c] = 1;
        run_session("postrst");

        for (int i = 0; i < 40; i++) begin
            random_stim();
            run_session($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
